// File: rtl/bcd_conv_arbiter.sv
// -----------------------------------------------------------------------------
// bcd_conv_arbiter
//
// Shares one 8-bit binary-to-BCD converter among N_REQ requesters. A round-robin
// search picks the next requester, its operand is latched and handed to the
// converter with a one-cycle start pulse, and the 12-bit BCD result is returned
// to the winner together with a one-cycle, one-hot ack.
//
// Optional feature macro: BCD_ARB_TIMEOUT_EN
//   defined   : WAIT-state watchdog; after TIMEOUT_CYCLES cycles without
//               conv_done_tick the winner is acked with rsp_err=1, rsp_bcd=0.
//   undefined : WAIT waits indefinitely, rsp_err is constant 0.
//
// Parameters
//   N_REQ           number of requesters (>= 2)
//   TIMEOUT_CYCLES  watchdog limit in clk cycles (only with BCD_ARB_TIMEOUT_EN)
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous, active-high reset
//   req             per-requester level request
//   req_bin         per-requester operand, slice i = [8*i+7:8*i]
//   ack             one-hot, one-cycle pulse to the served requester
//   rsp_bcd         result {hundreds,tens,units}, valid with |ack
//   rsp_id          index of the acked requester, valid with |ack
//   rsp_err         result invalid (watchdog expired), valid with |ack
//   busy            high in every state except IDLE
//   conv_start      one-cycle start pulse to the converter
//   conv_bin        operand to the converter, stable from LAUNCH to end of WAIT
//   conv_ready      converter idle
//   conv_done_tick  converter finished, conv_bcd valid this cycle
//   conv_bcd        converter result
// -----------------------------------------------------------------------------
module bcd_conv_arbiter #(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [8*N_REQ-1:0]         req_bin,
   output logic [N_REQ-1:0]           ack,
   output logic [11:0]                rsp_bcd,
   output logic [$clog2(N_REQ)-1:0]   rsp_id,
   output logic                       rsp_err,
   output logic                       busy,
   output logic                       conv_start,
   output logic [7:0]                 conv_bin,
   input  logic                       conv_ready,
   input  logic                       conv_done_tick,
   input  logic [11:0]                conv_bcd
);

   localparam int IW = $clog2(N_REQ);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_RESP
   } state_t;

   state_t          state_reg;
   logic [IW-1:0]   rr_ptr_reg;
   logic [IW-1:0]   idx_reg;
   logic [IW-1:0]   grant_idx;
   logic            grant_found;
   logic [7:0]      operand [N_REQ];

   generate
      if (N_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
         $error("bcd_conv_arbiter: N_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign operand[gi] = req_bin[8*gi +: 8];
      end
   endgenerate

   // Round-robin search: walk the offsets from the highest down to zero so the
   // last hit (smallest offset from rr_ptr) wins without needing a break.
   always_comb begin
      int cand;
      cand        = 0;
      grant_idx   = '0;
      grant_found = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = int'(rr_ptr_reg) + k;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         if (req[IW'(cand)]) begin
            grant_idx   = IW'(cand);
            grant_found = 1'b1;
         end
      end
   end

`ifdef BCD_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wait_cnt_reg;
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= S_IDLE;
         rr_ptr_reg <= '0;
         idx_reg    <= '0;
         ack        <= '0;
         rsp_bcd    <= '0;
         rsp_id     <= '0;
         busy       <= 1'b0;
         conv_start <= 1'b0;
         conv_bin   <= '0;
`ifdef BCD_ARB_TIMEOUT_EN
         rsp_err      <= 1'b0;
         wait_cnt_reg <= '0;
`endif
      end else begin
         // Pulsed outputs default low; each state raises them only when needed.
         conv_start <= 1'b0;
         ack        <= '0;
         case (state_reg)
            S_IDLE: begin
               if (grant_found && conv_ready) begin
                  idx_reg    <= grant_idx;
                  conv_bin   <= operand[grant_idx];
                  rr_ptr_reg <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                  conv_start <= 1'b1;
                  busy       <= 1'b1;
                  state_reg  <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
`ifdef BCD_ARB_TIMEOUT_EN
               wait_cnt_reg <= '0;
`endif
               state_reg <= S_WAIT;
            end
            S_WAIT: begin
               if (conv_done_tick) begin
                  rsp_bcd   <= conv_bcd;
                  rsp_id    <= idx_reg;
                  ack       <= N_REQ'(1) << idx_reg;
`ifdef BCD_ARB_TIMEOUT_EN
                  rsp_err   <= 1'b0;
`endif
                  state_reg <= S_RESP;
               end
`ifdef BCD_ARB_TIMEOUT_EN
               // The counter holds the number of completed WAIT cycles; the
               // TIMEOUT_CYCLES-th one without done_tick ends the wait.
               else if (wait_cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
                  rsp_bcd   <= 12'h000;
                  rsp_id    <= idx_reg;
                  ack       <= N_REQ'(1) << idx_reg;
                  rsp_err   <= 1'b1;
                  state_reg <= S_RESP;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
               end
`endif
            end
            S_RESP: begin
               busy      <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: begin
               busy      <= 1'b0;
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bcd_conv_arbiter
//
// Self-checking bench for bcd_conv_arbiter (N_REQ=4). A behavioural converter
// with random latency answers conv_start; expected winners and results come
// from a round-robin "first pending after the last served" rule and decimal
// arithmetic. Define BCD_ARB_TIMEOUT_EN to also exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_bcd_conv_arbiter;

   localparam int N  = 4;
   localparam int TO = 64;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     req = '0;
   logic [8*N-1:0]   req_bin = '0;
   logic [N-1:0]     ack;
   logic [11:0]      rsp_bcd;
   logic [1:0]       rsp_id;
   logic             rsp_err;
   logic             busy;
   logic             conv_start;
   logic [7:0]       conv_bin;
   logic             conv_ready;
   logic             conv_done_tick = 1'b0;
   logic [11:0]      conv_bcd = '0;

   int checks = 0;
   int errors = 0;
   int last_idx = N - 1;

   bit   hold_not_ready = 1'b0;
   bit   never_done = 1'b0;
   int   force_lat = -1;
   logic model_ready = 1'b1;
   bit   model_active = 1'b0;
   int   model_cnt = 0;
   logic [7:0] model_op = '0;

   bcd_conv_arbiter #(
      .N_REQ          (N),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req            (req),
      .req_bin        (req_bin),
      .ack            (ack),
      .rsp_bcd        (rsp_bcd),
      .rsp_id         (rsp_id),
      .rsp_err        (rsp_err),
      .busy           (busy),
      .conv_start     (conv_start),
      .conv_bin       (conv_bin),
      .conv_ready     (conv_ready),
      .conv_done_tick (conv_done_tick),
      .conv_bcd       (conv_bcd)
   );

   always #5 clk = ~clk;

   assign conv_ready = model_ready && !hold_not_ready;

   function automatic logic [11:0] to_bcd(input logic [7:0] b);
      int v;
      v = int'(b);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic int next_winner(input logic [N-1:0] mask, input int last);
      for (int k = 1; k <= N; k++) begin
         if (mask[(last + k) % N]) return (last + k) % N;
      end
      return 0;
   endfunction

   // Behavioural converter: accepts conv_start, answers after 1+lat cycles.
   always @(negedge clk) begin
      conv_done_tick = 1'b0;
      if (rst) begin
         model_active = 1'b0;
         model_ready  = 1'b1;
      end else if (model_active) begin
         if (model_cnt == 0) begin
            model_active = 1'b0;
            model_ready  = 1'b1;
            if (!never_done) begin
               conv_done_tick = 1'b1;
               conv_bcd       = to_bcd(model_op);
            end
         end else begin
            model_cnt--;
         end
      end else if (conv_start) begin
         model_active = 1'b1;
         model_ready  = 1'b0;
         model_op     = conv_bin;
         model_cnt    = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 4));
      end
   end

   task automatic wait_ack(input int max_cyc, output bit got, output int cyc);
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
         if (|ack) got = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      last_idx = N - 1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({ack, rsp_bcd, rsp_id, rsp_err} !== '0) begin
         errors++;
         $display("FAIL reset_rsp: got ack=%b bcd=%h id=%0d err=%b required all 0", ack, rsp_bcd, rsp_id, rsp_err);
      end
      checks++;
      if ({busy, conv_start, conv_bin} !== '0) begin
         errors++;
         $display("FAIL reset_conv: got busy=%b start=%b bin=%h required all 0", busy, conv_start, conv_bin);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      bit got; int cyc;
      req_bin[7:0] = 8'd255;
      req = 4'b0001;
      @(negedge clk);
      checks++;
      if ({conv_start, busy, conv_bin} !== {1'b1, 1'b1, 8'd255}) begin
         errors++;
         $display("FAIL single_launch: got start=%b busy=%b bin=%0d required 1 1 255", conv_start, busy, conv_bin);
      end
      @(negedge clk);
      checks++;
      if (conv_start !== 1'b0) begin
         errors++;
         $display("FAIL single_start_pulse: got start=%b required 0", conv_start);
      end
      wait_ack(100, got, cyc);
      checks++;
      if ({got, ack, rsp_id, rsp_bcd, rsp_err} !== {1'b1, 4'b0001, 2'd0, 12'h255, 1'b0}) begin
         errors++;
         $display("FAIL single_rsp: got got=%b ack=%b id=%0d bcd=%h err=%b required 1 0001 0 255 0", got, ack, rsp_id, rsp_bcd, rsp_err);
      end
      $display("txn single: id=%0d bcd=%h err=%b", rsp_id, rsp_bcd, rsp_err);
      req = '0;
      last_idx = 0;
      @(negedge clk);
      checks++;
      if ({ack, busy} !== '0) begin
         errors++;
         $display("FAIL single_after: got ack=%b busy=%b required 0 0", ack, busy);
      end
   endtask

   task automatic test_bin_edges();
      bit got; int cyc;
      logic [7:0] vals [2];
      vals[0] = 8'd0;
      vals[1] = 8'd99;
      for (int v = 0; v < 2; v++) begin
         req_bin[23:16] = vals[v];
         req = 4'b0100;
         wait_ack(100, got, cyc);
         checks++;
         if ({got, ack, rsp_id, rsp_bcd, rsp_err} !== {1'b1, 4'b0100, 2'd2, to_bcd(vals[v]), 1'b0}) begin
            errors++;
            $display("FAIL edge_%0d: got got=%b ack=%b id=%0d bcd=%h err=%b required 1 0100 2 %h 0", vals[v], got, ack, rsp_id, rsp_bcd, rsp_err, to_bcd(vals[v]));
         end
         $display("txn edge: id=%0d bcd=%h err=%b", rsp_id, rsp_bcd, rsp_err);
         req = '0;
         last_idx = 2;
         @(negedge clk);
      end
   endtask

   task automatic test_round_robin();
      bit got; int cyc; logic [N-1:0] ea;
      do_reset();
      for (int i = 0; i < N; i++) req_bin[8*i +: 8] = 8'(10 * (i + 1));
      req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         ea = '0;
         ea[t % N] = 1'b1;
         wait_ack(100, got, cyc);
         checks++;
         if ({got, ack, rsp_id, rsp_bcd, rsp_err} !== {1'b1, ea, 2'(t % N), to_bcd(8'(10 * (t % N + 1))), 1'b0}) begin
            errors++;
            $display("FAIL rr_%0d: got got=%b ack=%b id=%0d bcd=%h required ack=%b id=%0d bcd=%h", t, got, ack, rsp_id, rsp_bcd, ea, t % N, to_bcd(8'(10 * (t % N + 1))));
         end
         $display("txn rr: id=%0d bcd=%h err=%b", rsp_id, rsp_bcd, rsp_err);
         if (t == 4) req = '0;
      end
      last_idx = 0;
      @(negedge clk);
   endtask

   task automatic test_not_ready();
      bit got; int cyc;
      hold_not_ready = 1'b1;
      req_bin[15:8] = 8'd42;
      req = 4'b0010;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if ({conv_start, busy} !== 2'b00) begin
            errors++;
            $display("FAIL not_ready_hold: got start=%b busy=%b required 0 0", conv_start, busy);
         end
      end
      hold_not_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({conv_start, busy} !== 2'b11) begin
         errors++;
         $display("FAIL not_ready_release: got start=%b busy=%b required 1 1", conv_start, busy);
      end
      wait_ack(100, got, cyc);
      checks++;
      if ({got, ack, rsp_id, rsp_bcd} !== {1'b1, 4'b0010, 2'd1, 12'h042}) begin
         errors++;
         $display("FAIL not_ready_rsp: got got=%b ack=%b id=%0d bcd=%h required 1 0010 1 042", got, ack, rsp_id, rsp_bcd);
      end
      $display("txn not_ready: id=%0d bcd=%h err=%b", rsp_id, rsp_bcd, rsp_err);
      req = '0;
      last_idx = 1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit got; int cyc;
      force_lat = 20;
      req_bin[23:16] = 8'd123;
      req = 4'b0100;
      @(negedge clk);
      checks++;
      if (conv_start !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_launch: got start=%b required 1", conv_start);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      req = '0;
      #1;
      checks++;
      if ({ack, rsp_bcd, rsp_id, rsp_err, busy, conv_start, conv_bin} !== '0) begin
         errors++;
         $display("FAIL rstmid_clear: got ack=%b bcd=%h id=%0d err=%b busy=%b start=%b bin=%h required all 0", ack, rsp_bcd, rsp_id, rsp_err, busy, conv_start, conv_bin);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({ack, busy} !== '0) begin
            errors++;
            $display("FAIL rstmid_hold: got ack=%b busy=%b required 0 0", ack, busy);
         end
      end
      rst = 1'b0;
      force_lat = -1;
      @(negedge clk);
      // rr_ptr must be back at 0: with req[1] and req[3] both up, 1 goes first.
      req_bin[15:8]  = 8'd5;
      req_bin[31:24] = 8'd200;
      req = 4'b1010;
      wait_ack(100, got, cyc);
      checks++;
      if ({got, ack, rsp_id, rsp_bcd} !== {1'b1, 4'b0010, 2'd1, 12'h005}) begin
         errors++;
         $display("FAIL rstmid_first: got got=%b ack=%b id=%0d bcd=%h required 1 0010 1 005", got, ack, rsp_id, rsp_bcd);
      end
      $display("txn rstmid: id=%0d bcd=%h err=%b", rsp_id, rsp_bcd, rsp_err);
      req = 4'b1000;
      wait_ack(100, got, cyc);
      checks++;
      if ({got, ack, rsp_id, rsp_bcd} !== {1'b1, 4'b1000, 2'd3, 12'h200}) begin
         errors++;
         $display("FAIL rstmid_second: got got=%b ack=%b id=%0d bcd=%h required 1 1000 3 200", got, ack, rsp_id, rsp_bcd);
      end
      $display("txn rstmid: id=%0d bcd=%h err=%b", rsp_id, rsp_bcd, rsp_err);
      req = '0;
      last_idx = 3;
      @(negedge clk);
   endtask

   task automatic test_random();
      bit got; int cyc; int w;
      logic [N-1:0] pend; logic [N-1:0] ea; logic [11:0] eb;
      logic [7:0] ops [N];
      pend = '0;
      for (int i = 0; i < N; i++) ops[i] = '0;
      @(negedge clk);
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               ops[i]  = 8'($urandom_range(0, 255));
            end
         end
         if (pend == '0) begin
            w = int'($urandom_range(0, N - 1));
            pend[w] = 1'b1;
            ops[w]  = 8'($urandom_range(0, 255));
         end
         req = pend;
         for (int i = 0; i < N; i++) req_bin[8*i +: 8] = ops[i];
         w  = next_winner(pend, last_idx);
         eb = to_bcd(ops[w]);
         ea = '0;
         ea[w] = 1'b1;
         wait_ack(100, got, cyc);
         checks++;
         if ({got, ack, rsp_id, rsp_bcd, rsp_err} !== {1'b1, ea, 2'(w), eb, 1'b0}) begin
            errors++;
            $display("FAIL rand_%0d: got got=%b ack=%b id=%0d bcd=%h err=%b required ack=%b id=%0d bcd=%h err=0", t, got, ack, rsp_id, rsp_bcd, rsp_err, ea, w, eb);
         end
         $display("txn rand: pend=%b id=%0d bcd=%h err=%b", pend, rsp_id, rsp_bcd, rsp_err);
         last_idx = w;
         // Usually the served requester withdraws; sometimes it asks again.
         if (t == 39 || $urandom_range(0, 3) != 0) pend[w] = 1'b0;
         else ops[w] = 8'($urandom_range(0, 255));
         if (t == 39) pend = '0;
         req = pend;
         for (int i = 0; i < N; i++) req_bin[8*i +: 8] = ops[i];
         @(negedge clk);
         checks++;
         if ({ack, busy} !== '0) begin
            errors++;
            $display("FAIL rand_idle_%0d: got ack=%b busy=%b required 0 0", t, ack, busy);
         end
      end
   endtask

`ifdef BCD_ARB_TIMEOUT_EN
   task automatic test_timeout();
      bit got; int cyc;
      never_done = 1'b1;
      force_lat = 0;
      req_bin[7:0] = 8'd77;
      req = 4'b0001;
      @(negedge clk);
      checks++;
      if (conv_start !== 1'b1) begin
         errors++;
         $display("FAIL timeout_launch: got start=%b required 1", conv_start);
      end
      wait_ack(TO + 20, got, cyc);
      checks++;
      if ({got, ack, rsp_id, rsp_bcd, rsp_err} !== {1'b1, 4'b0001, 2'd0, 12'h000, 1'b1}) begin
         errors++;
         $display("FAIL timeout_rsp: got got=%b ack=%b id=%0d bcd=%h err=%b required 1 0001 0 000 1", got, ack, rsp_id, rsp_bcd, rsp_err);
      end
      checks++;
      if (cyc != TO + 1) begin
         errors++;
         $display("FAIL timeout_latency: got %0d cycles after launch required %0d", cyc, TO + 1);
      end
      $display("txn timeout: id=%0d bcd=%h err=%b", rsp_id, rsp_bcd, rsp_err);
      req = '0;
      never_done = 1'b0;
      force_lat = -1;
      last_idx = 0;
      @(negedge clk);
      req_bin[7:0]  = 8'd1;
      req_bin[15:8] = 8'd2;
      req = 4'b0011;
      wait_ack(100, got, cyc);
      checks++;
      if ({got, ack, rsp_id, rsp_bcd, rsp_err} !== {1'b1, 4'b0010, 2'd1, 12'h002, 1'b0}) begin
         errors++;
         $display("FAIL timeout_rr: got got=%b ack=%b id=%0d bcd=%h err=%b required 1 0010 1 002 0", got, ack, rsp_id, rsp_bcd, rsp_err);
      end
      $display("txn timeout_rr: id=%0d bcd=%h err=%b", rsp_id, rsp_bcd, rsp_err);
      req = '0;
      last_idx = 1;
      @(negedge clk);
   endtask
`endif

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      test_reset();
      test_single();
      test_bin_edges();
      test_round_robin();
      test_not_ready();
      test_reset_mid();
      test_random();
`ifdef BCD_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
